sha3_burst_fetch_ctrl: RTL
==========================

// Module: sha3_burst_fetch_ctrl
// PURPOSE
//  Sequences bus read bursts that fill the 128-in/64-out bus FIFO feeding the SHA3 core.
//  Splits a message (base, length in 128-bit beats) into bursts of at most MAX_BEATS.
//  Issues a burst only when the FIFO can take the whole burst; never overflows it.
//  Sits between the SHA3 top-level sequencer (start/done) and the burst bus master port.
// PARAMETERS
//  FIFO_DEPTH  32   FIFO depth in 64-bit words; must match the FIFO instance
//  MAX_BEATS   8    max beats per burst; power of 2, 2*MAX_BEATS <= FIFO_DEPTH
//  ADDR_W      32   bus byte-address width
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      async active-low reset
//  start       in   1      1-cycle pulse; sampled in IDLE only
//  base_addr   in   ADDR_W message byte address; bits [3:0] must be 0
//  len_beats   in   16     message length in 128-bit beats; 0 is legal
//  abort       in   1      level; stop after any in-flight burst completes
//  busy        out  1      high from the cycle after start until done
//  done        out  1      1-cycle pulse at completion, abort or error
//  err         out  1      sticky until next start; misaligned base
//  bus_req     out  1      burst request; held until bus_ack
//  bus_addr    out  ADDR_W burst start address; stable while bus_req
//  bus_len     out  8      beats-1 of this burst; stable while bus_req
//  bus_ack     in   1      request accepted in this cycle
//  bus_rvalid  in   1      read beat valid
//  bus_rdata   in   128    read beat data
//  bus_rlast   in   1      last beat of burst
//  fifo_flush  out  1      1-cycle pulse to FIFO sync reset, cycle after start
//  fifo_wr_en  out  1      FIFO write (one beat = two 64-bit words)
//  fifo_wr_data out 128    FIFO write data
//  fifo_level  in   $clog2(FIFO_DEPTH)+1  FIFO word count
// BEHAVIOUR
//  Reset: state IDLE; every output 0; address/remaining counters 0.
//  States: IDLE, FLUSH, CHECK, REQ, DATA, SETTLE, DONE.
//  IDLE: start -> latch base/len; base[3:0]!=0 -> DONE with err=1; else FLUSH.
//  FLUSH: fifo_flush=1 for one cycle -> CHECK. start while busy is ignored.
//  CHECK: rem==0 or abort -> DONE. beats=min(rem,MAX_BEATS).
//   Go REQ only if FIFO_DEPTH-fifo_level >= 2*beats; else stay (stall).
//  REQ: bus_req=1, bus_len=beats-1; on bus_ack -> DATA. abort ignored here.
//  DATA: each bus_rvalid -> fifo_wr_en=1, fifo_wr_data=bus_rdata, registered, 1 cycle later.
//   Beat counter counts down; rvalid&rlast -> SETTLE; addr+=16*beats; rem-=beats.
//   rlast before counter expiry or beats after it: err=1, DONE after the burst.
//  SETTLE: one idle cycle so fifo_level reflects final write -> CHECK.
//  DONE: done=1, busy=0 next cycle -> IDLE.
//  One burst outstanding max; back-to-back bursts separated by >=2 cycles.
//  Address arithmetic modulo 2^ADDR_W; no 4 KiB boundary split (bus owns that).
//  len_beats=0: start -> FLUSH -> CHECK -> DONE, no bus_req.
//  Async reset mid-burst: all state cleared; remaining bus beats are the bus's problem.
// CONFIGURATION
//  SHA3_FETCH_PERF_EN defined: adds outputs perf_stall_cyc[31:0] (cycles in CHECK blocked
//   on space) and perf_bursts[15:0] (acked bursts); both cleared on start, saturate.
//  Undefined: no counters, no extra ports; behaviour otherwise identical.
// STRUCTURE
//  sha3_bus_pkg: fetch state enum, BEAT_BYTES=16, WORDS_PER_BEAT=2, bus_len width.
//  One sub-module: sha3_fifo_space_chk (combinational free-space >= 2*beats compare).
//  Everything else (FSM, counters, write register) in this module.
// TESTING
//  base=0x1000,len=20,MAX_BEATS=8,empty FIFO -> bursts (0x1000,7),(0x1080,7),(0x1100,3), done.
//  fifo_level=20 held, len=8 -> no bus_req until level<=16, then (base,7).
//  base=0x1004 -> no bus_req, err=1, done pulse 1 cycle after start.
//  abort raised during DATA of burst 1 of 3 -> burst 1 fully written, no burst 2, done.
//  len=0 -> fifo_flush pulse, done, zero bus_req / fifo_wr_en.
//  rst_n low mid-DATA -> all outputs 0 asynchronously, IDLE; next start runs cleanly.

Source files
------------

// File: rtl/sha3_bus_pkg.sv
// Shared definitions for the SHA3 bus fetch path: beat geometry, burst length width, fetch FSM states.
package sha3_bus_pkg;

    localparam int BEAT_BYTES     = 16;
    localparam int WORDS_PER_BEAT = 2;
    localparam int BUS_LEN_W      = 8;
    localparam int BEAT_ALIGN_W   = $clog2(BEAT_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_CHECK,
        ST_REQ,
        ST_DATA,
        ST_SETTLE,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/sha3_fifo_space_chk.sv
// Combinational check that the bus FIFO has room for a whole burst (two 64-bit words per beat).
module sha3_fifo_space_chk
    import sha3_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BEATS  = 8
) (
    input  logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic [$clog2(MAX_BEATS):0]  beats,
    output logic                        space_ok
);

    logic [31:0] level_w;
    logic [31:0] free_w;
    logic [31:0] need_w;

    always_comb begin
        level_w  = 32'(fifo_level);
        // A level above depth can only be a glitch on the FIFO side; treat it as full.
        free_w   = (level_w >= 32'(FIFO_DEPTH)) ? 32'd0 : 32'(FIFO_DEPTH) - level_w;
        need_w   = 32'(beats) * 32'(WORDS_PER_BEAT);
        space_ok = (free_w >= need_w);
    end

endmodule

// File: rtl/sha3_burst_fetch_ctrl.sv
// Splits a SHA3 message fetch into bus read bursts that always fit in the bus FIFO.
// Optional macro SHA3_FETCH_PERF_EN adds saturating stall-cycle and burst counters.
//
// state  | meaning
// IDLE   | waiting for start
// FLUSH  | one-cycle FIFO sync reset
// CHECK  | pick next burst size, wait for FIFO room
// REQ    | burst request held until bus_ack
// DATA   | receiving beats, forwarding to FIFO
// SETTLE | let fifo_level catch up with last write
// DONE   | one-cycle completion pulse
module sha3_burst_fetch_ctrl
    import sha3_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BEATS  = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [15:0]                 len_beats,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        bus_req,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [BUS_LEN_W-1:0]        bus_len,
    input  logic                        bus_ack,
    input  logic                        bus_rvalid,
    input  logic [127:0]                bus_rdata,
    input  logic                        bus_rlast,
    output logic                        fifo_flush,
    output logic                        fifo_wr_en,
    output logic [127:0]                fifo_wr_data,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef SHA3_FETCH_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cyc,
    output logic [15:0]                 perf_bursts
`endif
);

    localparam int BEATS_W = $clog2(MAX_BEATS) + 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        rem_q, rem_d;
    logic [BEATS_W-1:0] beats_q, beats_d;
    logic [BEATS_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               perr_q, perr_d;
    logic               wr_en_q, wr_en_d;
    logic [127:0]       wr_data_q, wr_data_d;

    logic [BEATS_W-1:0] beats_c;
    logic               space_ok;
    logic               beat_err;

    assign beats_c = (rem_q >= 16'(MAX_BEATS)) ? BEATS_W'(MAX_BEATS) : BEATS_W'(rem_q);

    sha3_fifo_space_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_space_chk (
        .fifo_level (fifo_level),
        .beats      (beats_c),
        .space_ok   (space_ok)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        perr_d    = perr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        beat_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    addr_d = base_addr;
                    rem_d  = len_beats;
                    if (base_addr[BEAT_ALIGN_W-1:0] != '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_CHECK;
            ST_CHECK: begin
                if (rem_q == 16'd0 || abort) begin
                    state_d = ST_DONE;
                end else if (space_ok) begin
                    beats_d = beats_c;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    cnt_d   = beats_q;
                    perr_d  = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_rvalid) begin
                    // Beats past the expected count are dropped so the FIFO can never overflow.
                    if (cnt_q == '0) begin
                        beat_err = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = bus_rdata;
                        cnt_d     = cnt_q - 1'b1;
                        if (bus_rlast && cnt_q != BEATS_W'(1)) begin
                            beat_err = 1'b1;
                        end
                    end
                    perr_d = perr_q | beat_err;
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    if (bus_rlast) begin
                        if (perr_q || beat_err) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(beats_q) * ADDR_W'(BEAT_BYTES);
                            rem_d   = rem_q - 16'(beats_q);
                            state_d = ST_SETTLE;
                        end
                    end
                end
            end
            ST_SETTLE: state_d = ST_CHECK;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            perr_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beats_q   <= beats_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            perr_q    <= perr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;
    assign bus_req      = (state_q == ST_REQ);
    assign bus_addr     = bus_req ? addr_q : '0;
    assign bus_len      = bus_req ? (BUS_LEN_W'(beats_q) - BUS_LEN_W'(1)) : '0;
    assign fifo_flush   = (state_q == ST_FLUSH);
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;

`ifdef SHA3_FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] bursts_q, bursts_d;
    logic        stall_c;

    assign stall_c = (state_q == ST_CHECK) && (rem_q != 16'd0) && !abort && !space_ok;

    always_comb begin
        stall_d  = stall_q;
        bursts_d = bursts_q;
        if (state_q == ST_IDLE && start) begin
            stall_d  = '0;
            bursts_d = '0;
        end else begin
            if (stall_c && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
            if (state_q == ST_REQ && bus_ack && bursts_q != '1) begin
                bursts_d = bursts_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bursts_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bursts_q <= bursts_d;
        end
    end

    assign perf_stall_cyc = stall_q;
    assign perf_bursts    = bursts_q;
`endif

endmodule
